// File: rtl/memterceptor_wait.sv
// memterceptor_wait
//   Address interceptor between the CPU bus and the memory array and a
//   window of peripherals. The top PFX_W address bits all set select the
//   peripheral window. The next CH_SEL_W bits pick one of 2^CH_SEL_W
//   channels. Memory accesses complete in one cycle. A peripheral access
//   latches the channel and the operation, then stalls the CPU until that
//   channel reports ready. Read data is returned registered, with a
//   one-cycle RD_VALID pulse.
//
//   Optional macro MEMTERCEPTOR_WAIT_TIMEOUT_EN: a peripheral access that
//   stays unready for TIMEOUT BUSY cycles is forced to complete. A forced
//   read returns all ones, and BUS_ERR pulses for one cycle.
//
// Ports
//   CLK, RESET            clock (rising edge), async active-high reset
//   ADR, READ, WRITE      CPU request, held stable while STALL=1
//   STALL                 CPU must hold its request
//   READ_DATA, RD_VALID   registered read data and its one-cycle valid
//   ADR_IS_MEM/ADR_IS_PER combinational address decode
//   MEM_DATA, MEM_WRITE   memory read data in, memory write enable out
//   PER_SEL               one-hot channel select, active during BUSY
//   PER_READ, PER_WRITE   peripheral strobes, held during BUSY
//   PER_DATA, PER_READY   per-channel read data (DATA_W slices), ready
//   BUS_ERR               timeout pulse (tied 0 without the macro)
module memterceptor_wait #(
    parameter int unsigned ADR_W    = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PFX_W    = 5,
    parameter int unsigned CH_SEL_W = 1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [ADR_W-1:0]                   ADR,
    input  logic                               READ,
    input  logic                               WRITE,
    output logic                               STALL,
    output logic [DATA_W-1:0]                  READ_DATA,
    output logic                               RD_VALID,
    output logic                               ADR_IS_MEM,
    output logic                               ADR_IS_PER,
    input  logic [DATA_W-1:0]                  MEM_DATA,
    output logic                               MEM_WRITE,
    output logic [(1<<CH_SEL_W)-1:0]           PER_SEL,
    output logic                               PER_READ,
    output logic                               PER_WRITE,
    input  logic [(1<<CH_SEL_W)*DATA_W-1:0]    PER_DATA,
    input  logic [(1<<CH_SEL_W)-1:0]           PER_READY,
    output logic                               BUS_ERR
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CH_SEL_W-1:0] ch_q, ch_d;
    logic                op_write_q, op_write_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                adr_is_per;
    logic [CH_SEL_W-1:0] ch_in;
    logic                ready_sel;

    // Address bits below the channel field do not take part in the decode.
    if (ADR_W > PFX_W + CH_SEL_W) begin : g_adr_low
        logic adr_low_unused;
        assign adr_low_unused = ^ADR[ADR_W-PFX_W-CH_SEL_W-1:0];
    end

`ifdef MEMTERCEPTOR_WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;
`endif

    always_comb begin
        adr_is_per = &ADR[ADR_W-1 -: PFX_W];
        ch_in      = ADR[ADR_W-PFX_W-1 -: CH_SEL_W];
        ready_sel  = PER_READY[ch_q];

        state_d     = state_q;
        ch_d        = ch_q;
        op_write_d  = op_write_q;
        read_data_d = read_data_q;
        rd_valid_d  = 1'b0;
        STALL       = 1'b0;
        MEM_WRITE   = 1'b0;
        PER_SEL     = '0;
        PER_READ    = 1'b0;
        PER_WRITE   = 1'b0;
`ifdef MEMTERCEPTOR_WAIT_TIMEOUT_EN
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                MEM_WRITE = WRITE & ~adr_is_per;
                if ((READ | WRITE) & adr_is_per) begin
                    STALL      = 1'b1;
                    state_d    = S_BUSY;
                    ch_d       = ch_in;
                    // WRITE has priority when both strobes are high.
                    op_write_d = WRITE;
`ifdef MEMTERCEPTOR_WAIT_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end else if (READ & ~WRITE) begin
                    read_data_d = MEM_DATA;
                    rd_valid_d  = 1'b1;
                end
            end
            default: begin
                PER_SEL[ch_q] = 1'b1;
                PER_READ      = ~op_write_q;
                PER_WRITE     = op_write_q;
                STALL         = ~ready_sel;
                if (ready_sel) begin
                    state_d = S_IDLE;
                    if (!op_write_q) begin
                        read_data_d = PER_DATA[int'(ch_q)*DATA_W +: DATA_W];
                        rd_valid_d  = 1'b1;
                    end
`ifdef MEMTERCEPTOR_WAIT_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    // Forced completion; ready has already lost this cycle.
                    STALL     = 1'b0;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    if (!op_write_q) begin
                        read_data_d = '1;
                        rd_valid_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
        endcase

        ADR_IS_PER = adr_is_per;
        ADR_IS_MEM = ~adr_is_per;
        READ_DATA  = read_data_q;
        RD_VALID   = rd_valid_q;
`ifdef MEMTERCEPTOR_WAIT_TIMEOUT_EN
        BUS_ERR = bus_err_q;
`else
        BUS_ERR = 1'b0;
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            op_write_q  <= 1'b0;
            read_data_q <= '0;
            rd_valid_q  <= 1'b0;
`ifdef MEMTERCEPTOR_WAIT_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            op_write_q  <= op_write_d;
            read_data_q <= read_data_d;
            rd_valid_q  <= rd_valid_d;
`ifdef MEMTERCEPTOR_WAIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

endmodule

// File: doc/memterceptor_wait.md
Name: memterceptor_wait

Overview:
- Parametrised successor to the single-peripheral address interceptor.
- Splits the CPU address space into one memory region and a peripheral window at the top of the map.
- Divides the window into 2^CH_SEL_W peripheral channels, each with a ready handshake.
- Stalls the CPU until the selected peripheral responds, and returns read data registered.
- Sits between the CPU bus and the memory array / FFT and other peripherals. Write data goes to memory and peripherals directly on the shared bus, not through this block.

Parameters:
- ADR_W, 8, address width.
- DATA_W, 8, data width.
- PFX_W, 5, number of top address bits that must all be 1 to select the peripheral window.
- CH_SEL_W, 1, address bits directly below the prefix that select the channel; NUM_CH = 2^CH_SEL_W. PFX_W + CH_SEL_W must be ≤ ADR_W.
- TIMEOUT, 15, BUSY cycles before a forced completion (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ADR  in  ADR_W  CPU address; held stable while STALL=1.
- READ  in  1  CPU read request; held while STALL=1.
- WRITE  in  1  CPU write request; held while STALL=1.
- STALL  out  1  CPU must hold its request; an access completes on a rising edge where STALL=0.
- READ_DATA  out  DATA_W  registered read data.
- RD_VALID  out  1  one-cycle pulse: READ_DATA was updated by a read.
- ADR_IS_MEM  out  1  combinational decode: address is in the memory region.
- ADR_IS_PER  out  1  combinational decode: address is in the peripheral window.
- MEM_DATA  in  DATA_W  combinational memory read data.
- MEM_WRITE  out  1  memory write enable.
- PER_SEL  out  NUM_CH  one-hot channel select; all zero when idle.
- PER_READ  out  1  peripheral read strobe, held during the access.
- PER_WRITE  out  1  peripheral write strobe, held during the access.
- PER_DATA  in  NUM_CH*DATA_W  peripheral read data; channel k occupies bits [k*DATA_W +: DATA_W].
- PER_READY  in  NUM_CH  per-channel ready.
- BUS_ERR  out  1  one-cycle timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Decode:
  - ADR_IS_PER = AND of ADR[ADR_W-1 -: PFX_W].
  - ADR_IS_MEM = ~ADR_IS_PER.
  - Channel index ch = ADR[ADR_W-PFX_W-1 -: CH_SEL_W].
- Request: req = READ | WRITE. If READ and WRITE are both high, the access is a write and READ is ignored.
- FSM states: IDLE, BUSY.
- IDLE, memory access:
  - STALL=0.
  - MEM_WRITE = WRITE & ADR_IS_MEM, combinational, same cycle.
  - A read captures MEM_DATA into READ_DATA at the edge; RD_VALID=1 the following cycle (latency 1).
  - Back-to-back memory accesses run every cycle.
- IDLE, peripheral access:
  - STALL=1 combinationally.
  - MEM_WRITE=0.
  - At the edge: latch ch and op into registers, go to BUSY.
- BUSY:
  - PER_SEL = one-hot(latched ch).
  - PER_READ / PER_WRITE follow the latched op.
  - STALL = ~PER_READY[latched ch]. Ready from other channels is ignored.
  - ADR changes during BUSY are ignored because ch is latched.
  - On the edge where the selected ready is high: a read loads that channel's PER_DATA slice into READ_DATA and pulses RD_VALID next cycle; the FSM returns to IDLE.
  - Minimum peripheral access is 2 cycles, with STALL high for exactly 1.
  - MEM_WRITE=0 throughout BUSY.
- After completion the next request is evaluated in IDLE with no dead cycle.
- READ_DATA holds its value between reads. Writes never change READ_DATA and never pulse RD_VALID.
- Reset values: state IDLE, READ_DATA=0, RD_VALID=0, PER_SEL=0, PER_READ=0, PER_WRITE=0, BUS_ERR=0, timeout counter 0.
  - A RESET asserted mid-BUSY abandons the access immediately (asynchronously); no RD_VALID follows.
- STALL, MEM_WRITE, ADR_IS_* are combinational from the state and inputs. While RESET is high, STALL equals the IDLE decode.

Optional Feature:
- Macro: MEMTERCEPTOR_WAIT_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) counts BUSY cycles with the selected ready low.
  - When the count reaches TIMEOUT, STALL is forced to 0 for that cycle.
  - At that edge: a read loads all ones into READ_DATA with RD_VALID; BUS_ERR pulses 1 the next cycle; the FSM returns to IDLE; the counter clears.
  - If ready and timeout coincide, ready wins and BUS_ERR stays 0.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - BUS_ERR is tied to 0.

Test Plan (defaults: window 0xF8–0xFF; ch0 = 0xF8–0xFB; ch1 = 0xFC–0xFF):
- Memory read: READ at ADR=0x10, MEM_DATA=0x5A → STALL=0; next cycle RD_VALID=1, READ_DATA=0x5A; PER_SEL=00 throughout.
- Memory write: WRITE at ADR=0xF7 → MEM_WRITE=1 in the same cycle, ADR_IS_MEM=1, STALL=0, no RD_VALID.
- Peripheral read with wait states: READ at ADR=0xFD, PER_DATA ch1=0xC3, PER_READY[1] rising 3 cycles after the request → STALL high 3 cycles; PER_SEL=10 and PER_READ=1 during BUSY; then RD_VALID=1, READ_DATA=0xC3. PER_READY[0]=1 throughout must not complete the access.
- Peripheral write, ready already high: WRITE at ADR=0xF9, PER_READY=01 → STALL high exactly 1 cycle; PER_SEL=01 and PER_WRITE=1 for 1 cycle; MEM_WRITE=0; READ_DATA unchanged.
- Reset mid-access: READ at 0xFC, no ready, RESET asserted on the 2nd BUSY cycle → PER_SEL=00, PER_READ=0, READ_DATA=0 immediately; no RD_VALID after release.
- Timeout (macro defined, TIMEOUT=15): READ at 0xF8, ready never asserted → STALL released after 15 BUSY cycles; READ_DATA=0xFF with RD_VALID=1; BUS_ERR=1 for one cycle. Macro undefined: STALL is still high after 100 cycles.
